stream_grabber: RTL and testbench



---
 rtl/stream_grabber.sv | 137 +++++++++++++
 tb/tb_stream_grabber.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_grabber.sv
`default_nettype none
// ============================================================================
// Module      : stream_grabber
// Description : Circular capture of a sample stream with a byte-wide dump,
//               oldest sample first, MSB first, over a valid/ready link.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_grabber #(
    parameter int DAT_WIDTH = 72,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [DAT_WIDTH-1:0] data_in,
    input  logic                 data_in_valid,
    input  logic                 start_harvest,
    output logic                 reporting,
    output logic [7:0]           byte_out,
    output logic                 byte_out_valid,
    input  logic                 byte_out_ready
);

    localparam int c_BPW   = DAT_WIDTH / 8;
    localparam int c_DEPTH = 1 << ADDR_BITS;
    localparam int c_IDX_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    localparam logic [ADDR_BITS:0] c_FULL     = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BPW - 1);

    localparam logic [1:0] S_CAPTURE = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_SHIFT   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [DAT_WIDTH-1:0] r_mem [c_DEPTH];

    logic [1:0]           r_state;
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_words;
    logic [c_IDX_W-1:0]   r_byte_idx;
    logic [DAT_WIDTH-1:0] r_shift;
    logic                 r_reporting;
    logic                 r_valid;

    logic                 w_wr_en;
    logic [ADDR_BITS-1:0] w_wr_ptr_nxt;
    logic [ADDR_BITS:0]   w_count_nxt;
    logic [ADDR_BITS-1:0] w_rd_start;
    logic                 w_xfer;

    assign w_wr_en      = (r_state == S_CAPTURE) && data_in_valid;
    assign w_wr_ptr_nxt = w_wr_en ? (r_wr_ptr + ADDR_BITS'(1)) : r_wr_ptr;
    assign w_count_nxt  = (w_wr_en && (r_count != c_FULL)) ?
                          (r_count + (ADDR_BITS + 1)'(1)) : r_count;
    // Oldest address, taking a same-cycle write into account; at full
    // occupancy the low bits of the count are zero so this is the write pointer.
    assign w_rd_start   = w_wr_ptr_nxt - w_count_nxt[ADDR_BITS-1:0];
    assign w_xfer       = r_valid && byte_out_ready;

    // Sample memory: one write port, one registered read port, no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_CAPTURE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_words     <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_reporting <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_CAPTURE: begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                    r_count  <= w_count_nxt;
                    if (start_harvest) begin
                        r_state     <= S_LOAD;
                        r_rd_ptr    <= w_rd_start;
                        r_words     <= w_count_nxt;
                        r_reporting <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (r_words == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_byte_idx <= '0;
                        r_valid    <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_xfer) begin
                        if (r_byte_idx == c_LAST_IDX) begin
                            r_valid <= 1'b0;
                            r_words <= r_words - (ADDR_BITS + 1)'(1);
                            if (r_words == (ADDR_BITS + 1)'(1)) begin
                                r_state <= S_DONE;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
                                r_state  <= S_LOAD;
                            end
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                        end
                    end
                end

                default: begin
                    // Dump finished: drop the harvested samples, keep wr_ptr.
                    r_count     <= '0;
                    r_reporting <= 1'b0;
                    r_state     <= S_CAPTURE;
                end
            endcase
        end
    end

    assign reporting      = r_reporting;
    assign byte_out_valid = r_valid;
    assign byte_out       = r_shift[DAT_WIDTH-1 -: 8];

endmodule
`default_nettype wire

// File: tb/tb_stream_grabber.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_grabber
// Description : Directed self-checking bench for stream_grabber.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_grabber;

    logic        clk;
    logic        arst;
    logic [71:0] data_in;
    logic        data_in_valid;
    logic        start_harvest;
    logic        reporting;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_out_ready;

    int          n_assert;
    int          n_fail;
    logic [7:0]  got[$];
    int          hi_cyc;

    stream_grabber #(
        .DAT_WIDTH (72),
        .ADDR_BITS (4)
    ) u_dut (
        .clk            (clk),
        .arst           (arst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .start_harvest  (start_harvest),
        .reporting      (reporting),
        .byte_out       (byte_out),
        .byte_out_valid (byte_out_valid),
        .byte_out_ready (byte_out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [71:0] v, input int gap);
        data_in       = v;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Issues a harvest (optionally with a same-cycle write) and collects the dump.
    task automatic run_dump(input bit rnd_ready, input bit noise, input bit wr_with,
                            input logic [71:0] wr_val, input bit expect_bytes);
        int         cyc;
        int         last_x;
        int         first_v;
        bit         hold;
        bit         done;
        logic [7:0] hbyte;
        got.delete();
        start_harvest = 1'b1;
        data_in_valid = wr_with;
        data_in       = wr_val;
        @(negedge clk);
        start_harvest = 1'b0;
        data_in_valid = 1'b0;
        chk("rep_rise", reporting, 1);
        cyc = 0; last_x = -1; first_v = -1; hold = 0; done = 0; hi_cyc = 0; hbyte = '0;
        while (!done && cyc < 3000) begin
            if (hold) begin
                chk("hold_byte", byte_out, hbyte);
                chk("hold_valid", byte_out_valid, 1);
            end
            if (!reporting) begin
                done          = 1;
                data_in_valid = 1'b0;
                start_harvest = 1'b0;
                chk("valid_idle", byte_out_valid, 0);
            end else begin
                hi_cyc++;
                if (byte_out_valid && first_v < 0) first_v = cyc;
                byte_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (noise) begin
                    data_in       = {8'h5a, $urandom, $urandom};
                    data_in_valid = 1'b1;
                    start_harvest = 1'($urandom_range(0, 1));
                end
                if (byte_out_valid && byte_out_ready) begin
                    got.push_back(byte_out);
                    last_x = cyc;
                end
                hold  = byte_out_valid && !byte_out_ready;
                hbyte = byte_out;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk("dump_timeout", 0, 1);
        if (expect_bytes) begin
            chk("first_valid_lat", (first_v >= 0 && first_v <= 3), 1);
            chk("rep_fall_gap", cyc - last_x, 2);
        end
        byte_out_ready = 1'b1;
    endtask

    // Expected dump: consecutive word values first..first+n-1, each MSB first.
    task automatic cmp_words(input string tag, input int first, input int n);
        logic [7:0]  exp_b[$];
        logic [71:0] v;
        int          lim;
        for (int i = 0; i < n; i++) begin
            v = 72'(first + i);
            for (int b = 8; b >= 0; b--) exp_b.push_back(v[b*8 +: 8]);
        end
        chk({tag, "_len"}, got.size(), exp_b.size());
        lim = (got.size() < exp_b.size()) ? got.size() : exp_b.size();
        for (int k = 0; k < lim; k++) chk({tag, "_byte"}, got[k], exp_b[k]);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        arst           = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        start_harvest  = 1'b0;
        byte_out_ready = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_reporting", reporting, 0);
        chk("rst_valid", byte_out_valid, 0);
        arst = 1'b0;
        byte_out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_reporting", reporting, 0);
        chk("idle_valid", byte_out_valid, 0);
        chk("idle_byte", byte_out, 0);

        // Partial fill
        for (int i = 0; i < 5; i++) send_word(72'(i), 0);
        run_dump(0, 0, 0, '0, 1);
        cmp_words("partial", 0, 5);

        // Wrap / overflow with random input gaps
        for (int i = 0; i < 40; i++) send_word(72'(i), $urandom_range(0, 2));
        run_dump(0, 0, 0, '0, 1);
        cmp_words("wrap", 24, 16);

        // Same scenario under random backpressure
        for (int i = 0; i < 40; i++) send_word(72'(i), $urandom_range(0, 2));
        run_dump(1, 0, 0, '0, 1);
        cmp_words("bp", 24, 16);

        // Freeze: traffic and harvest requests during the dump are ignored
        for (int i = 50; i < 56; i++) send_word(72'(i), 0);
        run_dump(0, 1, 0, '0, 1);
        cmp_words("freeze", 50, 6);

        // Re-arm; the last word is written in the harvest cycle itself
        send_word(72'd100, 1);
        send_word(72'd101, 0);
        run_dump(1, 0, 1, 72'd102, 1);
        cmp_words("rearm", 100, 3);

        // Abort mid-dump with asynchronous reset
        for (int i = 0; i < 4; i++) send_word(72'(200 + i), 0);
        start_harvest = 1'b1;
        @(negedge clk);
        start_harvest = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pre_valid", byte_out_valid, 1);
        #2 arst = 1'b1;
        #1;
        chk("abort_reporting", reporting, 0);
        chk("abort_valid", byte_out_valid, 0);
        chk("abort_byte", byte_out, 0);
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // Empty harvest: two reporting cycles, no bytes
        run_dump(0, 0, 0, '0, 0);
        chk("empty_len", got.size(), 0);
        chk("empty_hi_cycles", hi_cyc, 2);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
